// File: rtl/riscv_regfile_sb_if.sv
// Decode/WB-side bus of the scoreboarded register file: read ports, write port, reserve, flush, error.
interface riscv_regfile_sb_if #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_RD_PORTS = 2
);
    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] raddr_i;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;
    logic [NUM_RD_PORTS-1:0]                 rbusy_o;
    logic                                    we_i;
    logic [ADDR_WIDTH-1:0]                   waddr_i;
    logic [DATA_WIDTH-1:0]                   wdata_i;
    logic                                    reserve_i;
    logic [ADDR_WIDTH-1:0]                   reserve_addr_i;
    logic                                    flush_i;
    logic                                    err_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, reserve_i, reserve_addr_i, flush_i,
        input  rdata_o, rbusy_o, err_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, reserve_i, reserve_addr_i, flush_i,
        output rdata_o, rbusy_o, err_o
    );
endinterface

// File: rtl/riscv_regfile_sb.sv
// Integer register file with per-register pending scoreboard, combinational read ports
// and optional same-cycle write-to-read bypass. x0 is hardwired to zero.
module riscv_regfile_sb #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned BYPASS       = 1
) (
    input  logic               clk,
    input  logic               rst,
    riscv_regfile_sb_if.slave  bus
);
    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic        BYP_EN   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0]                   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]                     pend_q;
    logic [NUM_REGS-1:0]                     pend_d;
    logic                                    err_q;
    logic                                    err_d;
    logic                                    wr_act;
    logic                                    res_act;
    logic                                    waw;
    logic                                    wr_np;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rdata_c;
    logic [NUM_RD_PORTS-1:0]                 rbusy_c;

    // Scoreboard next state: clear on write, newer reserve wins, flush overrides all.
    always_comb begin
        wr_act  = bus.we_i && (bus.waddr_i != '0);
        res_act = bus.reserve_i && (bus.reserve_addr_i != '0);
        pend_d  = pend_q;
        if (wr_act) begin
            pend_d[bus.waddr_i] = 1'b0;
        end
        if (res_act) begin
            pend_d[bus.reserve_addr_i] = 1'b1;
        end
        if (bus.flush_i) begin
            pend_d = '0;
        end
        waw   = res_act && pend_q[bus.reserve_addr_i] && !bus.flush_i &&
                !(wr_act && (bus.waddr_i == bus.reserve_addr_i));
        wr_np = wr_act && !pend_q[bus.waddr_i];
        err_d = err_q | waw | wr_np;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr_act) begin
                regs_q[bus.waddr_i] <= bus.wdata_i;
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Read ports: a bypassed result is by definition no longer pending.
    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            if (bus.raddr_i[p] != '0) begin
                if (BYP_EN && bus.we_i && (bus.waddr_i == bus.raddr_i[p])) begin
                    rdata_c[p] = bus.wdata_i;
                end else begin
                    rdata_c[p] = regs_q[bus.raddr_i[p]];
                    rbusy_c[p] = pend_q[bus.raddr_i[p]];
                end
            end
        end
    end

    assign bus.rdata_o = rdata_c;
    assign bus.rbusy_o = rbusy_c;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_riscv_regfile_sb;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    riscv_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2)) if1 ();
    riscv_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2)) if0 ();

    riscv_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .BYPASS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    riscv_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2), .BYPASS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    assign if0.raddr_i        = if1.raddr_i;
    assign if0.we_i           = if1.we_i;
    assign if0.waddr_i        = if1.waddr_i;
    assign if0.wdata_i        = if1.wdata_i;
    assign if0.reserve_i      = if1.reserve_i;
    assign if0.reserve_addr_i = if1.reserve_addr_i;
    assign if0.flush_i        = if1.flush_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if1.we_i           = 1'b0;
        if1.waddr_i        = '0;
        if1.wdata_i        = '0;
        if1.reserve_i      = 1'b0;
        if1.reserve_addr_i = '0;
        if1.flush_i        = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        if1.raddr_i = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state across all addresses
        for (int a = 0; a < 32; a++) begin
            if1.raddr_i[0] = 5'(a);
            if1.raddr_i[1] = 5'(31 - a);
            #1;
            chk("rst_rdata0", if1.rdata_o[0], 32'h0);
            chk("rst_rdata1", if1.rdata_o[1], 32'h0);
            chk("rst_busy",   {30'h0, if1.rbusy_o}, 32'h0);
        end
        chk("rst_err", {31'h0, if1.err_o}, 32'h0);

        // Reserve x5, write it one cycle later
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd5;
        tick();
        idle();
        if1.raddr_i[0] = 5'd5; if1.raddr_i[1] = 5'd5;
        #1;
        chk("x5_busy_pending", {31'h0, if1.rbusy_o[0]}, 32'h1);
        chk("x5_data_old", if1.rdata_o[0], 32'h0);
        if1.we_i = 1'b1; if1.waddr_i = 5'd5; if1.wdata_i = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        chk("x5_rdata0", if1.rdata_o[0], 32'hDEADBEEF);
        chk("x5_rdata1", if1.rdata_o[1], 32'hDEADBEEF);
        chk("x5_busy",   {30'h0, if1.rbusy_o}, 32'h0);
        chk("x5_err",    {31'h0, if1.err_o}, 32'h0);

        // x0: reserve and write in the same cycle
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd0;
        if1.we_i = 1'b1; if1.waddr_i = 5'd0; if1.wdata_i = 32'hFFFFFFFF;
        if1.raddr_i[0] = 5'd0; if1.raddr_i[1] = 5'd0;
        #1;
        chk("x0_same_rdata", if1.rdata_o[0], 32'h0);
        tick();
        idle();
        #1;
        chk("x0_rdata", if1.rdata_o[1], 32'h0);
        chk("x0_busy",  {30'h0, if1.rbusy_o}, 32'h0);
        chk("x0_err",   {31'h0, if1.err_o}, 32'h0);

        // Bypass vs. no bypass on write cycle of x7
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd7;
        tick();
        idle();
        if1.we_i = 1'b1; if1.waddr_i = 5'd7; if1.wdata_i = 32'h12345678;
        if1.raddr_i[1] = 5'd7;
        #1;
        chk("byp1_rdata", if1.rdata_o[1], 32'h12345678);
        chk("byp1_busy",  {31'h0, if1.rbusy_o[1]}, 32'h0);
        chk("byp0_rdata", if0.rdata_o[1], 32'h0);
        chk("byp0_busy",  {31'h0, if0.rbusy_o[1]}, 32'h1);
        tick();
        idle();
        #1;
        chk("byp0_next_rdata", if0.rdata_o[1], 32'h12345678);
        chk("byp0_next_busy",  {31'h0, if0.rbusy_o[1]}, 32'h0);
        chk("byp1_next_rdata", if1.rdata_o[1], 32'h12345678);
        chk("byp0_err",        {31'h0, if0.err_o}, 32'h0);

        // Overlap: write x3 and re-reserve x3 in one cycle
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd3;
        tick();
        if1.reserve_addr_i = 5'd4;
        tick();
        if1.reserve_addr_i = 5'd3;
        if1.we_i = 1'b1; if1.waddr_i = 5'd3; if1.wdata_i = 32'h00000333;
        tick();
        idle();
        if1.raddr_i[0] = 5'd3; if1.raddr_i[1] = 5'd4;
        #1;
        chk("ovl_x3_busy",  {31'h0, if1.rbusy_o[0]}, 32'h1);
        chk("ovl_x3_rdata", if1.rdata_o[0], 32'h00000333);
        chk("ovl_x4_busy",  {31'h0, if1.rbusy_o[1]}, 32'h1);
        chk("ovl_err",      {31'h0, if1.err_o}, 32'h0);

        // Flush clears both, even against a concurrent reserve
        if1.flush_i = 1'b1; if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd4;
        tick();
        idle();
        #1;
        chk("flush_busy", {30'h0, if1.rbusy_o}, 32'h0);
        chk("flush_err",  {31'h0, if1.err_o}, 32'h0);

        // WAW: reserve x9 twice
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd9;
        tick();
        #1;
        chk("waw_first_err", {31'h0, if1.err_o}, 32'h0);
        tick();
        idle();
        #1;
        chk("waw_err", {31'h0, if1.err_o}, 32'h1);
        tick();
        tick();
        chk("waw_sticky", {31'h0, if1.err_o}, 32'h1);

        // Reset, then write x10 without reserve
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", {31'h0, if1.err_o}, 32'h0);
        if1.we_i = 1'b1; if1.waddr_i = 5'd10; if1.wdata_i = 32'hCAFE0010;
        tick();
        idle();
        if1.raddr_i[0] = 5'd10;
        #1;
        chk("np_rdata", if1.rdata_o[0], 32'hCAFE0010);
        chk("np_err",   {31'h0, if1.err_o}, 32'h1);

        // Reset mid-operation overrides a concurrent write
        if1.reserve_i = 1'b1; if1.reserve_addr_i = 5'd2;
        if1.we_i = 1'b1; if1.waddr_i = 5'd6; if1.wdata_i = 32'hA5A5A5A5;
        tick();
        idle();
        if1.raddr_i[0] = 5'd6; if1.raddr_i[1] = 5'd2;
        #1;
        chk("mid_x6_rdata", if1.rdata_o[0], 32'hA5A5A5A5);
        chk("mid_x2_busy",  {31'h0, if1.rbusy_o[1]}, 32'h1);
        rst = 1'b1;
        if1.we_i = 1'b1; if1.waddr_i = 5'd6; if1.wdata_i = 32'h00000001;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("midrst_x6_rdata", if1.rdata_o[0], 32'h0);
        chk("midrst_x2_busy",  {31'h0, if1.rbusy_o[1]}, 32'h0);
        chk("midrst_err",      {31'h0, if1.err_o}, 32'h0);
        chk("midrst_x10",      dut0.bus.rdata_o[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised integer register file with an integrated per-register scoreboard, replacing the fixed 2-read/1-write register file in the CPU decode stage. It provides `NUM_RD_PORTS` combinational read ports, one synchronous write port fed by WB, and an optional write-to-read bypass. A pending bit per register lets the decode stage detect RAW hazards on results still in flight (loads, multi-cycle ops). Register x0 reads as zero and is never written or marked pending.

## Interface
- `ADDR_WIDTH`, default 5: register address width; `2**ADDR_WIDTH` registers.
- `DATA_WIDTH`, default 32: register width.
- `NUM_RD_PORTS`, default 2: number of read ports, 1..4.
- `BYPASS`, default 1: 1 forwards same-cycle write data to matching reads; 0 disables forwarding.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `raddr_i` in `NUM_RD_PORTS`x`ADDR_WIDTH`: read addresses.
- `rdata_o` out `NUM_RD_PORTS`x`DATA_WIDTH`: read data, combinational.
- `rbusy_o` out `NUM_RD_PORTS`: the addressed register has a pending (unwritten) result.
- `we_i` in 1: write enable from WB.
- `waddr_i` in `ADDR_WIDTH`: write address.
- `wdata_i` in `DATA_WIDTH`: write data.
- `reserve_i` in 1: decode issues an instruction that will write `reserve_addr_i`.
- `reserve_addr_i` in `ADDR_WIDTH`: destination being reserved.
- `flush_i` in 1: clear all pending bits (pipeline flush on taken branch/jump).
- `err_o` out 1: sticky protocol error flag.

## Operation
- Storage: `2**ADDR_WIDTH` entries of `DATA_WIDTH` bits; entry 0 is not stored and reads as 0.
- Write: on a rising edge with `we_i`=1 and `waddr_i`!=0, the entry takes `wdata_i`. A write to x0 is ignored.
- Read port p: if `raddr_i[p]`==0, the port returns 0. Otherwise, if `BYPASS`=1, `we_i`=1 and `waddr_i`==`raddr_i[p]`, it returns `wdata_i`. Otherwise it returns the stored entry.
- Pending bit set: on an edge with `reserve_i`=1 and `reserve_addr_i`!=0.
- Pending bit clear: on an edge with `we_i`=1 and `waddr_i` matching, unless that address is set in the same cycle.
- Same-cycle reserve and write to the same address: the set wins, because the newer instruction owns the register. The data write still occurs.
- `flush_i`=1: on the edge, all pending bits clear, overriding any reserve in the same cycle. Register data and writes in that cycle are unaffected.
- `rbusy_o[p]` = pending[`raddr_i[p]`], forced to 0 when `raddr_i[p]`==0. With `BYPASS`=1 it is also forced to 0 when a same-cycle write matches and the bypass supplies the data.
- `err_o` sets on an edge in either of these cases, and holds until `rst`:
  - WAW: `reserve_i`=1 to a register that is already pending, with no clearing write or flush in that cycle.
  - Write to a non-pending register: `we_i`=1 to a non-zero register that is not pending.
- Writes to a non-pending register still update the data.

## Timing
- Reset (`rst`=1 at an edge):
  - All entries = 0, all pending = 0, `err_o` = 0.
  - Outputs after reset: `rdata_o` = 0 for every address, `rbusy_o` = 0.
  - `rst` overrides every concurrent write, reserve and flush.
- Read latency: 0 cycles, combinational from `raddr_i`, storage, and (with bypass) the write port.
- Write latency: data is visible through storage from the cycle after the edge. With `BYPASS`=1 it is also visible in the same cycle.
- Reserve latency: `rbusy_o` asserts from the cycle after the reserve edge.
- No handshake. The caller stalls decode while any used `rbusy_o`=1.

## Test plan
- Reset and data path:
  - Drive `rst` for 2 cycles, then read all 32 addresses -> every `rdata_o`=0, `rbusy_o`=0, `err_o`=0.
  - Reserve x5, then write x5=0xDEADBEEF one cycle later. Next cycle read x5 on both ports -> 0xDEADBEEF, busy 0.
- x0 handling: reserve x0 and write x0=0xFFFFFFFF in the same cycle -> x0 reads 0, busy 0, `err_o` stays 0.
- Bypass:
  - `BYPASS`=1: reserve x7, then on the write cycle (x7=0x12345678) read x7 on port 1 -> same-cycle 0x12345678, busy 0.
  - `BYPASS`=0: the same stimulus -> old value 0, busy 1. Next cycle -> 0x12345678, busy 0.
- Scoreboard overlap and flush:
  - Reserve x3 and x4 on consecutive cycles, then in one cycle write x3 and reserve x3 -> x3 busy stays 1 and holds the written data, x4 busy 1, `err_o`=0.
  - Assert `flush_i` -> both busy 0 the next cycle.
- Errors:
  - Reserve x9 twice with no intervening write -> `err_o`=1 after the second edge and remains 1.
  - After `rst`, write x10 without a reserve -> data is written and `err_o`=1.
- Reset mid-operation: reserve x2 and write x6=0xA5A5A5A5, then assert `rst` together with a write x6=0x1 -> x6 reads 0, x2 busy 0.
